// File: rtl/ascon_seq_pkg.sv
// Shared types and sizing helpers for the Ascon job sequencer.
package ascon_seq_pkg;

  localparam int NSHARES = 5;
  localparam int TAG_W   = 128;
  localparam int NONCE_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    CRST,
    LOAD,
    START,
    CAPT,
    DONE
  } seq_state_t;

  // Counter must hold every per-state count without wrapping.
  function automatic int cnt_width(input int load_len, input int timeout);
    int m;
    m = (load_len > TAG_W) ? load_len : TAG_W;
    if (timeout > m) m = timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ascon_share_piso.sv
// Parallel-in/serial-out for five shares of width W; MSB first, zero-filled once drained.
module ascon_share_piso
  import ascon_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_shift,
  input  logic [NSHARES*W-1:0] i_data,
  output logic [NSHARES-1:0]   o_bits
);

  logic [W-1:0] r_sr [NSHARES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSHARES; s++) r_sr[s] <= '0;
    end else if (i_load) begin
      for (int s = 0; s < NSHARES; s++) r_sr[s] <= i_data[s*W +: W];
    end else if (i_shift) begin
      for (int s = 0; s < NSHARES; s++) r_sr[s] <= {r_sr[s][W-2:0], 1'b0};
    end
  end

  for (genvar g = 0; g < NSHARES; g++) begin : g_out
    assign o_bits[g] = r_sr[g][W-1];
  end

endmodule

// File: rtl/ascon_job_sequencer.sv
// Runs one masked Ascon enc/dec job through the bit-serial core: reset, serial load,
// start/wait with timeout, then LSB-first capture of text and tag into a held result.
module ascon_job_sequencer
  import ascon_seq_pkg::*;
#(
  parameter int K        = 128,
  parameter int L        = 32,
  parameter int Y        = 32,
  parameter int LOAD_LEN = 130,
  parameter int TIMEOUT  = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic                       job_mode,
  input  logic [NSHARES*K-1:0]       job_key,
  input  logic [NSHARES*NONCE_W-1:0] job_nonce,
  input  logic [NSHARES*L-1:0]       job_ad,
  input  logic [NSHARES*Y-1:0]       job_text,
  output logic                       core_rst,
  output logic [NSHARES-1:0]         core_key_si,
  output logic [NSHARES-1:0]         core_nonce_si,
  output logic [NSHARES-1:0]         core_ad_si,
  output logic [NSHARES-1:0]         core_pt_si,
  output logic                       core_enc_start,
  output logic                       core_dec_start,
  input  logic                       core_enc_ready,
  input  logic                       core_dec_ready,
  input  logic                       core_text_so,
  input  logic                       core_tag_so,
  input  logic                       core_auth,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [Y-1:0]               res_text,
  output logic [TAG_W-1:0]           res_tag,
  output logic                       res_auth,
  output logic                       res_timeout,
  output logic                       busy
);

  localparam int CNT_W  = cnt_width(LOAD_LEN, TIMEOUT);
  localparam int TAG_IW = $clog2(TAG_W);
  localparam int TXT_IW = $clog2(Y);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_LEN - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CAPT_LAST = CNT_W'(TAG_W - 1);
  localparam logic [CNT_W-1:0] TEXT_LEN  = CNT_W'(Y);

  seq_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_mode;
  logic [Y-1:0]     r_text;
  logic [TAG_W-1:0] r_tag;
  logic             r_auth, r_tmo;
  logic             w_accept, w_shift, w_core_rdy, w_timeout_hit, w_capt_last;
  logic [NSHARES-1:0] w_key_bits, w_nonce_bits, w_ad_bits, w_pt_bits;

  assign w_accept   = job_ready & job_valid;
  assign w_core_rdy = r_mode ? core_dec_ready : core_enc_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = '0;
    job_ready      = 1'b0;
    core_rst       = 1'b0;
    core_enc_start = 1'b0;
    core_dec_start = 1'b0;
    w_shift        = 1'b0;
    w_timeout_hit  = 1'b0;
    w_capt_last    = 1'b0;
    case (r_state)
      IDLE: begin
        job_ready = 1'b1;
        core_rst  = 1'b1;
        if (job_valid) w_state_nxt = CRST;
      end
      CRST: begin
        core_rst    = 1'b1;
        w_state_nxt = LOAD;
      end
      LOAD: begin
        w_shift = 1'b1;
        if (r_cnt == LOAD_LAST) w_state_nxt = START;
        else                    w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      START: begin
        core_enc_start = ~r_mode;
        core_dec_start = r_mode;
        if (w_core_rdy) begin
          w_state_nxt = CAPT;
        end else if (r_cnt == WAIT_LAST) begin
          w_state_nxt   = DONE;
          w_timeout_hit = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      CAPT: begin
        if (r_cnt == CAPT_LAST) begin
          w_state_nxt = DONE;
          w_capt_last = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        if (res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
      r_text  <= '0;
      r_tag   <= '0;
      r_auth  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_mode <= job_mode;
        r_text <= '0;
        r_tag  <= '0;
        r_auth <= 1'b0;
        r_tmo  <= 1'b0;
      end
      if (w_timeout_hit) r_tmo <= 1'b1;
      if (r_state == CAPT) begin
        r_tag[r_cnt[TAG_IW-1:0]] <= core_tag_so;
        if (r_cnt < TEXT_LEN) r_text[r_cnt[TXT_IW-1:0]] <= core_text_so;
        if (w_capt_last) r_auth <= r_mode ? core_auth : 1'b1;
      end
    end
  end

  ascon_share_piso #(.W(K)) u_key (
    .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_shift(w_shift),
    .i_data(job_key), .o_bits(w_key_bits)
  );
  ascon_share_piso #(.W(NONCE_W)) u_nonce (
    .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_shift(w_shift),
    .i_data(job_nonce), .o_bits(w_nonce_bits)
  );
  ascon_share_piso #(.W(L)) u_ad (
    .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_shift(w_shift),
    .i_data(job_ad), .o_bits(w_ad_bits)
  );
  ascon_share_piso #(.W(Y)) u_pt (
    .clk(clk), .rst_n(rst_n), .i_load(w_accept), .i_shift(w_shift),
    .i_data(job_text), .o_bits(w_pt_bits)
  );

  // Shift registers hold live data in CRST; only expose bits while loading.
  assign core_key_si   = w_shift ? w_key_bits   : '0;
  assign core_nonce_si = w_shift ? w_nonce_bits : '0;
  assign core_ad_si    = w_shift ? w_ad_bits    : '0;
  assign core_pt_si    = w_shift ? w_pt_bits    : '0;

  assign res_valid   = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign res_text    = r_text;
  assign res_tag     = r_tag;
  assign res_auth    = r_auth;
  assign res_timeout = r_tmo;

endmodule
